// File: rtl/id_ex_pkg.sv
// rtl/id_ex_pkg.sv - shared opcodes, ALUOp encoding and control bundle for the ID/EX stage
package id_ex_pkg;

  // Major opcodes handled by this decoder
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // {funct7, funct3} is always ten bits wide in the base ISA
  localparam int ALU_CTRL_BITS = 10;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RTYPE  = 2'b10,
    ALU_ITYPE  = 2'b11
  } alu_op_t;

  typedef struct packed {
    logic alusrc;
    logic branch;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic regwrite;
    logic inv_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // Instructions whose rs2 field names a real source register
  function automatic logic opcode_uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  endfunction

endpackage

// File: rtl/id_ctrl_decode.sv
// rtl/id_ctrl_decode.sv - combinational instruction decode to controls, ALUOp and immediate
module id_ctrl_decode
  import id_ex_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output ctrl_t           ctrl,
  output alu_op_t         alu_op,
  output logic [XLEN-1:0] imm,
  output logic            uses_rs2
);

  logic [6:0] opcode;
  assign opcode   = instr[6:0];
  assign uses_rs2 = opcode_uses_rs2(opcode);

  // Opcode-driven control and immediate generation; unknown opcodes carry only inv_op
  always_comb begin
    ctrl   = CTRL_NONE;
    alu_op = ALU_ADD;
    imm    = '0;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl.regwrite = 1'b1;
        alu_op        = ALU_RTYPE;
      end
      OP_IALU: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        alu_op        = ALU_ITYPE;
        imm           = {{(XLEN-12){instr[31]}}, instr[31:20]};
      end
      OP_LOAD: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = 1'b1;
        imm           = {{(XLEN-12){instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 1'b1;
        imm           = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        ctrl.branch = 1'b1;
        alu_op      = ALU_BRANCH;
        imm         = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                       instr[30:25], instr[11:8], 1'b0};
      end
      default: begin
        ctrl.inv_op = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode plus ID/EX pipeline register; ID_EX_HAZARD_EN adds load-use bubbles
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int PC_W       = 64,
  parameter int ALU_CTRL_W = ALU_CTRL_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [PC_W-1:0]       in_pc,
  output logic [4:0]            rf_rs1_addr,
  output logic [4:0]            rf_rs2_addr,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_W-1:0]       out_pc,
  output logic [XLEN-1:0]       out_rs1_data,
  output logic [XLEN-1:0]       out_rs2_data,
  output logic [XLEN-1:0]       out_imm,
  output logic [4:0]            out_rs1,
  output logic [4:0]            out_rs2,
  output logic [4:0]            out_rd,
  output logic [ALU_CTRL_W-1:0] out_alu_control,
  output logic [1:0]            out_alu_op,
  output logic                  out_alusrc,
  output logic                  out_branch,
  output logic                  out_memread,
  output logic                  out_memwrite,
  output logic                  out_memtoreg,
  output logic                  out_regwrite,
  output logic                  out_inv_op
`ifdef ID_EX_HAZARD_EN
  ,
  output logic [31:0]           hazard_stall_cnt
`endif
);

  ctrl_t           dec_ctrl;
  alu_op_t         dec_alu_op;
  logic [XLEN-1:0] dec_imm;
  logic            dec_uses_rs2;
  logic            hazard;
  logic            accept;

  id_ctrl_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr    (in_instr),
    .ctrl     (dec_ctrl),
    .alu_op   (dec_alu_op),
    .imm      (dec_imm),
    .uses_rs2 (dec_uses_rs2)
  );

  assign rf_rs1_addr = in_instr[19:15];
  assign rf_rs2_addr = in_instr[24:20];

`ifdef ID_EX_HAZARD_EN
  // A load in EX whose destination feeds this instruction cannot forward in time
  assign hazard = out_valid && out_memread && (out_rd != 5'd0) &&
                  ((out_rd == in_instr[19:15]) ||
                   (dec_uses_rs2 && (out_rd == in_instr[24:20])));

  // Counts cycles a waiting instruction was held back by a load-use bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      hazard_stall_cnt <= '0;
    end else if (hazard && in_valid && !flush) begin
      hazard_stall_cnt <= hazard_stall_cnt + 32'd1;
    end
  end
`else
  logic hazard_unused;
  assign hazard        = 1'b0;
  assign hazard_unused = dec_uses_rs2;
`endif

  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Pipeline register: flush kills, accept loads, drain leaves a bubble, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_pc          <= '0;
      out_rs1_data    <= '0;
      out_rs2_data    <= '0;
      out_imm         <= '0;
      out_rs1         <= '0;
      out_rs2         <= '0;
      out_rd          <= '0;
      out_alu_control <= '0;
      out_alu_op      <= '0;
      out_alusrc      <= 1'b0;
      out_branch      <= 1'b0;
      out_memread     <= 1'b0;
      out_memwrite    <= 1'b0;
      out_memtoreg    <= 1'b0;
      out_regwrite    <= 1'b0;
      out_inv_op      <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid       <= 1'b1;
      out_pc          <= in_pc;
      out_rs1_data    <= rs1_data;
      out_rs2_data    <= rs2_data;
      out_imm         <= dec_imm;
      out_rs1         <= in_instr[19:15];
      out_rs2         <= in_instr[24:20];
      out_rd          <= in_instr[11:7];
      out_alu_control <= {in_instr[31:25], in_instr[14:12]};
      out_alu_op      <= dec_alu_op;
      out_alusrc      <= dec_ctrl.alusrc;
      out_branch      <= dec_ctrl.branch;
      out_memread     <= dec_ctrl.memread;
      out_memwrite    <= dec_ctrl.memwrite;
      out_memtoreg    <= dec_ctrl.memtoreg;
      out_regwrite    <= dec_ctrl.regwrite;
      out_inv_op      <= dec_ctrl.inv_op;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Parametrised decode plus ID/EX pipeline stage for the RV core. It decodes a 32-bit instruction into control signals and a sign-extended immediate, and registers them into the EX stage behind a valid/ready handshake. Adds behaviour the single-cycle decode lacks:
- stall/backpressure
- synchronous flush (branch redirect)
- invalid-opcode squash
- optional load-use hazard bubble insertion

It sits between the IF/ID register / register file and the EX stage.

Parameters:
- XLEN, 64: datapath width of register operands and immediate.
- PC_W, 64: program counter width.
- ALU_CTRL_W, 10: width of {funct7, funct3} ALU control field. Fixed by ISA; exposed for the package.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  32  instruction word
- in_pc  in  PC_W  PC of in_instr
- rf_rs1_addr  out  5  combinational in_instr[19:15] to register file
- rf_rs2_addr  out  5  combinational in_instr[24:20] to register file
- rs1_data  in  XLEN  register file read data 1, same cycle
- rs2_data  in  XLEN  register file read data 2, same cycle
- flush  in  1  kill the held entry and block acceptance this cycle
- out_valid  out  1  EX-side entry valid
- out_ready  in  1  EX accepts the entry
- out_pc  out  PC_W  registered PC
- out_rs1_data  out  XLEN  registered operand 1
- out_rs2_data  out  XLEN  registered operand 2
- out_imm  out  XLEN  registered sign-extended immediate
- out_rs1  out  5  registered rs1 index
- out_rs2  out  5  registered rs2 index
- out_rd  out  5  registered rd index
- out_alu_control  out  ALU_CTRL_W  registered {instr[31:25], instr[14:12]}
- out_alu_op  out  2  registered ALUOp: 00 add, 01 branch compare, 10 R-type, 11 I-type ALU
- out_alusrc, out_branch, out_memread, out_memwrite, out_memtoreg, out_regwrite  out  1 each  registered controls
- out_inv_op  out  1  registered invalid-opcode flag

Behaviour:
- Reset: every out_* register is 0, out_valid=0. in_ready follows the combinational equations below.
- Decode table (others → inv_op=1, all controls 0, imm 0):
  - 0110011 R-type: regwrite, alu_op 10
  - 0010011 I-ALU: regwrite, alusrc, alu_op 11
  - 0000011 load: regwrite, alusrc, memread, memtoreg
  - 0100011 store: alusrc, memwrite
  - 1100011 branch: branch, alu_op 01
- Immediates, sign-extended from instr[31] to XLEN:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
  - R: 0
- hazard = 0 unless ID_EX_HAZARD_EN is defined.
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Accept: in_valid && in_ready. On acceptance, all out_* load next edge and out_valid <= 1. Latency is 1 cycle.
- Drain without accept: if out_ready && !accept, out_valid <= 0 (bubble). Payload registers may hold stale values.
- Hold: if out_valid && !out_ready, all outputs stay stable. EX may rely on this.
- Flush: out_valid <= 0 next edge, no acceptance that cycle. Flush takes priority over hazard, accept and hold.
- Invalid opcode: the entry is still accepted with out_inv_op=1, and regwrite, memwrite, memread, branch are forced 0, so there are no architectural side effects.
- Back-to-back: full throughput, one instruction per cycle when out_ready=1 continuously.
- Reset mid-stream: the held entry is discarded, and in_ready is 1 the cycle after rst deasserts.

Optional Feature:
Macro: ID_EX_HAZARD_EN.
- Defined: hazard = out_valid && out_memread && out_rd!=0 && (out_rd==in_instr[19:15] || (uses_rs2 && out_rd==in_instr[24:20])). uses_rs2 is true for R-type, store and branch. This produces exactly one bubble per load-use pair, assuming WB→EX forwarding downstream. Also a 32-bit hazard_stall_cnt output that increments on each hazard cycle with in_valid=1, wraps at 2^32, and is cleared by rst.
- Undefined: hazard tied 0, no counter port; the downstream hazard unit must stall via in_valid/flush.

Decomposition:
- Package id_ex_pkg:
  - opcode localparams: OP_RTYPE, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH
  - ALUOp encodings as a 2-bit typedef alu_op_t
  - ctrl_t packed struct of the six control bits plus inv_op
- One natural sub-module: id_ctrl_decode. It is purely combinational: instruction in, ctrl_t, alu_op_t, imm and uses_rs2 out. id_ex_stage owns the handshake, pipeline register and hazard logic.

Test Plan:
- Reset then add x3,x1,x2 (0x002081B3), rs1_data=5, rs2_data=7, out_ready=1 → next cycle out_valid=1, out_rd=3, regwrite=1, alu_op=10, out_imm=0, operands 5/7.
- sw x2,-4(x1) (0xFE20AE23) then beq x1,x2,-8 (0xFE208CE3) back-to-back → out_imm=0xFFFF_FFFF_FFFF_FFFC with memwrite=1, then 0xFFFF_FFFF_FFFF_FFF8 with branch=1; in_ready stays 1.
- Hold EX entry with out_ready=0 for 3 cycles while in_valid=1 → in_ready=0 and outputs unchanged. Release → next instruction loaded the following cycle.
- Flush asserted with in_valid=1 and entry held → out_valid=0 next cycle, incoming instruction not accepted. Flush plus hazard in the same cycle → flush behaviour only.
- Opcode 0x7F (0x0000007F) → out_inv_op=1, all write/branch controls 0, out_valid=1.
- ID_EX_HAZARD_EN: lw x5,8(x1) (0x0080A283) followed by add x6,x5,x1 (0x00128333) → one cycle in_ready=0, one bubble (out_valid=0), add issues next, hazard_stall_cnt=1. Same sequence with add x6,x0,x1 → no stall.
